guess_controller: RTL
=====================

# guess_controller

Sequencing controller between the PS/2 letter decoder and the Hangman word-match datapath. It converts the decoder's held-key level plus letter code into single guess events. It filters repeated and non-letter keys, and runs a request/acknowledge handshake with the word matcher. It also tracks the guessed-letter mask and miss count, and decides win/lose and new-game transitions.

## Interface
- MAX_MISSES, default 6: number of wrong guesses that ends the round as lost (1..15).
- MW, default $clog2(MAX_MISSES+1): width of the miss counter; derived, not overridden.

- clk  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- pressed  in  1  decoder make/break level; high while a key is held.
- letter  in  5  decoder code: 0..25 = A..Z, 26 = Enter, 27 = no/unknown key.
- guess_req  out  1  request to matcher; held high until result_valid.
- guess_letter  out  5  letter under test (0..25); stable while guess_req is high.
- result_valid  in  1  one-cycle matcher acknowledge carrying result_hit/result_solved.
- result_hit  in  1  guessed letter occurs in the word.
- result_solved  in  1  all word letters now revealed.
- new_game  out  1  one-cycle pulse telling word selector/matcher to load a new word.
- guessed_mask  out  26  bit n set = letter n already guessed this round.
- misses  out  MW  wrong-guess count this round.
- playing  out  1  round in progress.
- won  out  1  round ended solved; held until next new_game.
- lost  out  1  round ended at MAX_MISSES; held until next new_game.
- dup_pulse  out  1  one-cycle pulse: letter already guessed, no request issued.

## Operation
- Input stage: pressed and letter are registered (pressed_q, letter_q), and pressed_q is registered again (pressed_q2).
- Key event is pressed_q & ~pressed_q2, evaluated on letter_q. One event per press; holding a key never repeats.
- FSM states: IDLE, WAIT_KEY, ISSUE, WAIT_RESULT, OVER.
- IDLE: on an Enter event, pulse new_game, clear mask and misses, and go to WAIT_KEY. Letter events are ignored.
- WAIT_KEY (playing=1), letter event 0..25:
  - If the mask bit is set: pulse dup_pulse and stay in WAIT_KEY.
  - Otherwise: latch guess_letter, set the mask bit, and go to ISSUE.
- WAIT_KEY: Enter and code 27 are ignored.
- ISSUE: guess_req=1 and go to WAIT_RESULT immediately. guess_req stays high through WAIT_RESULT.
- WAIT_RESULT, on result_valid:
  - result_solved=1: go to OVER with won=1. Misses are unchanged, regardless of result_hit.
  - result_hit=1 and not solved: return to WAIT_KEY.
  - result_hit=0: misses+1. If the new value equals MAX_MISSES, go to OVER with lost=1; otherwise return to WAIT_KEY.
- guess_req drops in the cycle after result_valid is sampled.
- OVER: an Enter event behaves as in IDLE (new_game pulse, clear, WAIT_KEY, won/lost cleared). Letters are ignored.
- Key events arriving in ISSUE/WAIT_RESULT are discarded (no queue).
- result_valid outside WAIT_RESULT is ignored.
- misses saturates at MAX_MISSES and never wraps.

## Timing
- Reset (async assert, synchronous release):
  - State: IDLE.
  - Outputs: guess_req=0, guess_letter=0, new_game=0, guessed_mask=0, misses=0, playing=0, won=0, lost=0, dup_pulse=0.
  - Input registers: pressed_q=pressed_q2=0.
- Key latency: pressed first sampled high at edge E0. The event is decoded in the following cycle. At edge E1 the FSM updates, so new_game/dup_pulse/mask bit are visible after E1, and guess_req rises after E2 (ISSUE→WAIT_RESULT keeps it high).
- result_valid sampled at edge Ek: misses/won/lost/state update at Ek, and guess_req is low after Ek.
- All outputs are registered. Pulses are exactly one cycle.
- Reset mid-handshake: guess_req drops asynchronously. The matcher must tolerate a request aborted by reset.

## Structure
- Shared package hangman_pkg:
  - Letter codes: LETTER_A=0, LETTER_Z=25, KEY_ENTER=26, KEY_NONE=27.
  - State enum.
  - Mask width 26.
- The keyboard decoder uses the same code constants.
- One natural sub-module: key_event_detect (2-stage register plus rising-edge detect, emitting event and letter_q). The FSM and counters stay in guess_controller.

## Test plan
- Reset then Enter held 5 cycles → exactly one new_game pulse, playing=1, mask=0, misses=0. A second Enter while playing → no pulse.
- Press C (2), matcher acks hit=1 solved=0 after 3 cycles → guess_req high 4 cycles with guess_letter=2, mask=0x0000004, misses=0.
- Press C again → dup_pulse once, guess_req stays 0.
- Six distinct letters all acked hit=0 with MAX_MISSES=6 → misses counts 1..6, lost=1 after the sixth ack, playing=0. A further letter press is ignored.
- Ack with hit=1 solved=1 → won=1, misses unchanged. Ack with hit=0 solved=1 → won=1, misses unchanged.
- Key press during WAIT_RESULT, then ack → no second request, and the mask is unchanged for that letter.
- Assert reset while guess_req=1 → all outputs at reset values immediately. After release, Enter restarts cleanly.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared Hangman definitions: key codes, controller state encoding and mask helpers.
// The keyboard decoder and the guess controller both use these code constants.
package hangman_pkg;

  localparam logic [4:0] LETTER_A  = 5'd0;
  localparam logic [4:0] LETTER_Z  = 5'd25;
  localparam logic [4:0] KEY_ENTER = 5'd26;
  localparam logic [4:0] KEY_NONE  = 5'd27;

  localparam int MASK_W = 26;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_KEY    = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_RESULT = 3'd3,
    ST_OVER        = 3'd4
  } state_t;

  // One-hot mask position for a letter code; callers guarantee code <= LETTER_Z.
  function automatic logic [MASK_W-1:0] letter_bit(input logic [4:0] code);
    return {{(MASK_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Registers the decoder's held-key level and code, then turns the level into a
// single event on the first cycle a key is seen held.
module key_event_detect
  import hangman_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pressed,
  input  logic [4:0] letter,
  output logic       key_event,
  output logic [4:0] letter_q
);

  logic pressed_q;
  logic pressed_q2;

  // Two-stage level pipeline; the code travels alongside the first stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed_q  <= 1'b0;
      pressed_q2 <= 1'b0;
      letter_q   <= KEY_NONE;
    end else begin
      pressed_q  <= pressed;
      pressed_q2 <= pressed_q;
      letter_q   <= letter;
    end
  end

  assign key_event = pressed_q & ~pressed_q2;

endmodule

// File: rtl/guess_controller.sv
// Hangman guess sequencer: turns key events into guess requests to the word
// matcher, tracks the guessed-letter mask and misses, and decides win/lose.
module guess_controller
  import hangman_pkg::*;
#(
  parameter int MAX_MISSES = 6,
  parameter int MW         = $clog2(MAX_MISSES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pressed,
  input  logic [4:0]        letter,
  output logic              guess_req,
  output logic [4:0]        guess_letter,
  input  logic              result_valid,
  input  logic              result_hit,
  input  logic              result_solved,
  output logic              new_game,
  output logic [MASK_W-1:0] guessed_mask,
  output logic [MW-1:0]     misses,
  output logic              playing,
  output logic              won,
  output logic              lost,
  output logic              dup_pulse
);

  logic        key_event;
  logic [4:0]  letter_q;
  state_t      state;
  state_t      state_nxt;
  logic              guess_req_nxt;
  logic [4:0]        guess_letter_nxt;
  logic              new_game_nxt;
  logic [MASK_W-1:0] mask_nxt;
  logic [MW-1:0]     misses_nxt;
  logic              playing_nxt;
  logic              won_nxt;
  logic              lost_nxt;
  logic              dup_nxt;
  logic              enter_evt;
  logic              letter_evt;

  key_event_detect u_key (
    .clk       (clk),
    .reset     (reset),
    .pressed   (pressed),
    .letter    (letter),
    .key_event (key_event),
    .letter_q  (letter_q)
  );

  assign enter_evt  = key_event && (letter_q == KEY_ENTER);
  assign letter_evt = key_event && (letter_q <= LETTER_Z);

  // State and every output are registered together so outputs never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      guess_req    <= 1'b0;
      guess_letter <= 5'd0;
      new_game     <= 1'b0;
      guessed_mask <= {MASK_W{1'b0}};
      misses       <= {MW{1'b0}};
      playing      <= 1'b0;
      won          <= 1'b0;
      lost         <= 1'b0;
      dup_pulse    <= 1'b0;
    end else begin
      state        <= state_nxt;
      guess_req    <= guess_req_nxt;
      guess_letter <= guess_letter_nxt;
      new_game     <= new_game_nxt;
      guessed_mask <= mask_nxt;
      misses       <= misses_nxt;
      playing      <= playing_nxt;
      won          <= won_nxt;
      lost         <= lost_nxt;
      dup_pulse    <= dup_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt        = state;
    guess_letter_nxt = guess_letter;
    new_game_nxt     = 1'b0;
    mask_nxt         = guessed_mask;
    misses_nxt       = misses;
    won_nxt          = won;
    lost_nxt         = lost;
    dup_nxt          = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (enter_evt) begin
          new_game_nxt = 1'b1;
          mask_nxt     = {MASK_W{1'b0}};
          misses_nxt   = {MW{1'b0}};
          won_nxt      = 1'b0;
          lost_nxt     = 1'b0;
          state_nxt    = ST_WAIT_KEY;
        end else begin
          state_nxt = state;
        end
      end
      ST_WAIT_KEY: begin
        if (letter_evt) begin
          if ((guessed_mask & letter_bit(letter_q)) != {MASK_W{1'b0}}) begin
            dup_nxt = 1'b1;
          end else begin
            guess_letter_nxt = letter_q;
            mask_nxt         = guessed_mask | letter_bit(letter_q);
            state_nxt        = ST_ISSUE;
          end
        end else begin
          state_nxt = ST_WAIT_KEY;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (result_valid) begin
          if (result_solved) begin
            won_nxt   = 1'b1;
            state_nxt = ST_OVER;
          end else if (result_hit) begin
            state_nxt = ST_WAIT_KEY;
          end else begin
            // Saturating increment; the round ends the moment the limit is hit.
            if (misses < MW'(MAX_MISSES)) begin
              misses_nxt = misses + MW'(1);
            end else begin
              misses_nxt = misses;
            end
            if (misses_nxt == MW'(MAX_MISSES)) begin
              lost_nxt  = 1'b1;
              state_nxt = ST_OVER;
            end else begin
              state_nxt = ST_WAIT_KEY;
            end
          end
        end else begin
          state_nxt = ST_WAIT_RESULT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    guess_req_nxt = (state_nxt == ST_WAIT_RESULT);
    playing_nxt   = (state_nxt == ST_WAIT_KEY) || (state_nxt == ST_ISSUE) ||
                    (state_nxt == ST_WAIT_RESULT);
  end

endmodule
